// File: rtl/store_buffer_unit_if.sv
// Execute-stage store request and AHB-Lite write-master signals of the store buffer unit.
// Modport slave is the store buffer's view; modport master is the driving environment.
interface store_buffer_unit_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) ();
  logic [2:0]                   funct3_in;
  logic [ADDR_W-1:0]            addr_in;
  logic [XLEN-1:0]              rs2_in;
  logic                         mem_wr_req_in;
  logic                         ahb_ready_in;
  logic                         stall_out;
  logic                         exc_out;
  logic                         empty_out;
  logic [$clog2(DEPTH+1)-1:0]   count_out;
  logic [ADDR_W-1:0]            daddrs_out;
  logic [1:0]                   ahb_btrans_out;
  logic                         hwrite_out;
  logic [2:0]                   hsize_out;
  logic [XLEN-1:0]              data_out;
  logic [XLEN/8-1:0]            wr_mask_out;

  modport slave (
    input  funct3_in, addr_in, rs2_in, mem_wr_req_in, ahb_ready_in,
    output stall_out, exc_out, empty_out, count_out, daddrs_out,
           ahb_btrans_out, hwrite_out, hsize_out, data_out, wr_mask_out
  );

  modport master (
    output funct3_in, addr_in, rs2_in, mem_wr_req_in, ahb_ready_in,
    input  stall_out, exc_out, empty_out, count_out, daddrs_out,
           ahb_btrans_out, hwrite_out, hsize_out, data_out, wr_mask_out
  );
endinterface

// File: rtl/store_buffer_unit.sv
// Posted-write store buffer: lane-aligns SB/SH/SW/SD stores, queues them in a FIFO and
// drains them as pipelined AHB-Lite NONSEQ writes (address phase overlaps previous data phase).
module store_buffer_unit #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  store_buffer_unit_if.slave   bus
);
  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic [OFF_W-1:0]  off_s;
  logic [1:0]        size_s;
  logic [XLEN-1:0]   dmask_s;
  logic [STRB_W-1:0] smask_s;
  logic              misaligned_s;
  logic              illegal_s;
  logic              exc_s;
  logic              full_s;
  logic              push_s;
  logic              pop_s;
  logic              head_valid_s;
  logic [XLEN-1:0]   entry_data_s;
  logic [STRB_W-1:0] entry_mask_s;

  logic [ADDR_W-1:0] addr_q_r [DEPTH];
  logic [XLEN-1:0]   data_q_r [DEPTH];
  logic [STRB_W-1:0] mask_q_r [DEPTH];
  logic [1:0]        size_q_r [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              dp_valid_r;
  logic [XLEN-1:0]   dp_data_r;
  logic [STRB_W-1:0] dp_mask_r;

  assign off_s  = bus.addr_in[OFF_W-1:0];
  assign size_s = bus.funct3_in[1:0];

  // Size decode: data/strobe masks and natural-alignment check per access size
  always_comb begin
    dmask_s      = {XLEN{1'b0}};
    smask_s      = {STRB_W{1'b0}};
    misaligned_s = 1'b0;
    case (size_s)
      2'b00: begin
        dmask_s      = XLEN'(8'hFF);
        smask_s      = STRB_W'(1'b1);
        misaligned_s = 1'b0;
      end
      2'b01: begin
        dmask_s      = XLEN'(16'hFFFF);
        smask_s      = STRB_W'(2'b11);
        misaligned_s = bus.addr_in[0];
      end
      2'b10: begin
        dmask_s      = XLEN'(32'hFFFF_FFFF);
        smask_s      = STRB_W'(4'hF);
        misaligned_s = (bus.addr_in[1:0] != 2'b00);
      end
      2'b11: begin
        dmask_s      = {XLEN{1'b1}};
        smask_s      = {STRB_W{1'b1}};
        misaligned_s = (off_s != {OFF_W{1'b0}});
      end
      default: begin
        dmask_s      = {XLEN{1'b0}};
        smask_s      = {STRB_W{1'b0}};
        misaligned_s = 1'b0;
      end
    endcase
  end

  // SD only exists on a 64-bit datapath
  assign illegal_s    = bus.funct3_in[2] | ((size_s == 2'b11) && (XLEN == 32));
  assign exc_s        = bus.mem_wr_req_in & (misaligned_s | illegal_s);
  assign full_s       = (count_r == CNT_W'(DEPTH));
  assign push_s       = bus.mem_wr_req_in & ~full_s & ~exc_s;
  assign head_valid_s = (count_r != {CNT_W{1'b0}});
  assign pop_s        = head_valid_s & bus.ahb_ready_in;

  assign entry_data_s = (bus.rs2_in & dmask_s) << {off_s, 3'b000};
  assign entry_mask_s = smask_s << off_s;

  // FIFO pointers and occupancy
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between push and pop
  always_ff @(posedge clk_in) begin
    if (push_s) begin
      addr_q_r[wr_ptr_r] <= bus.addr_in;
      data_q_r[wr_ptr_r] <= entry_data_s;
      mask_q_r[wr_ptr_r] <= entry_mask_s;
      size_q_r[wr_ptr_r] <= size_s;
    end
  end

  // Data-phase register: loads on address acceptance, retires on the next HREADY edge
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dp_valid_r <= 1'b0;
      dp_data_r  <= {XLEN{1'b0}};
      dp_mask_r  <= {STRB_W{1'b0}};
    end else if (bus.ahb_ready_in) begin
      if (pop_s) begin
        dp_valid_r <= 1'b1;
        dp_data_r  <= data_q_r[rd_ptr_r];
        dp_mask_r  <= mask_q_r[rd_ptr_r];
      end else begin
        dp_valid_r <= 1'b0;
        dp_mask_r  <= {STRB_W{1'b0}};
      end
    end
  end

  assign bus.stall_out      = full_s;
  assign bus.exc_out        = exc_s;
  assign bus.empty_out      = ~head_valid_s & ~dp_valid_r;
  assign bus.count_out      = count_r;
  assign bus.ahb_btrans_out = head_valid_s ? 2'b10 : 2'b00;
  assign bus.hwrite_out     = head_valid_s;
  assign bus.daddrs_out     = head_valid_s ? addr_q_r[rd_ptr_r] : {ADDR_W{1'b0}};
  assign bus.hsize_out      = head_valid_s ? {1'b0, size_q_r[rd_ptr_r]} : 3'b000;
  assign bus.data_out       = dp_data_r;
  assign bus.wr_mask_out    = dp_mask_r;
endmodule

// File: doc/store_buffer_unit.md
Name: store_buffer_unit

Overview:
Parametrised store unit with a posted-write buffer between the execute stage and the AHB-Lite data bus. It accepts SB/SH/SW stores (and SD when XLEN=64), lane-aligns data and builds byte strobes, queues them in a DEPTH-entry FIFO, and drains the FIFO as pipelined AHB NONSEQ write transfers. It adds buffering, back-pressure, misalignment/illegal-op detection and a drain indication for FENCE.

Parameters:
XLEN, 32, data width in bits; legal values 32 or 64.
DEPTH, 4, store-buffer entries; power of 2, >= 2.
ADDR_W, 32, byte-address width.

Ports:
clk_in  input  1  clock, rising edge.
rst_in  input  1  asynchronous reset, active-high.
funct3_in  input  3  store type: 000 SB, 001 SH, 010 SW, 011 SD (XLEN=64 only).
addr_in  input  ADDR_W  effective byte address.
rs2_in  input  XLEN  store source data, LSB-justified.
mem_wr_req_in  input  1  store request, valid for one cycle.
ahb_ready_in  input  1  AHB HREADY.
stall_out  output  1  buffer full; request not accepted this cycle.
exc_out  output  1  misaligned or illegal store; request dropped.
empty_out  output  1  FIFO empty and no data phase outstanding.
count_out  output  $clog2(DEPTH+1)  entries held in FIFO.
daddrs_out  output  ADDR_W  HADDR.
ahb_btrans_out  output  2  HTRANS: 00 IDLE, 10 NONSEQ.
hwrite_out  output  1  HWRITE.
hsize_out  output  3  HSIZE: 000 byte, 001 half, 010 word, 011 dword.
data_out  output  XLEN  HWDATA.
wr_mask_out  output  XLEN/8  byte write strobes for the data phase.

Behaviour:
- Reset (async, rst_in=1): FIFO emptied, count_out=0, ahb_btrans_out=00, hwrite_out=0, daddrs_out=0, hsize_out=0, data_out=0, wr_mask_out=0, data-phase-valid cleared, empty_out=1. Reset mid-transfer abandons all queued and in-flight stores.
- Lane offset off = addr_in[log2(XLEN/8)-1:0]. Entry data = (rs2_in masked to access size) << 8*off. Entry mask = size-mask << off. Size-masks: SB 1, SH 11b, SW 1111b, SD all ones.
- Misaligned: SH with addr[0]=1; SW with addr[1:0]!=0; SD with addr[2:0]!=0. Illegal: funct3[2]=1, or 011 when XLEN=32. exc_out = mem_wr_req_in & (misaligned | illegal), combinational; the store is not enqueued.
- stall_out = FIFO full, combinational, independent of a same-cycle pop. A request with stall_out=1 is dropped; the core must hold and retry. exc_out has priority over stall_out.
- Push when mem_wr_req_in & ~stall_out & ~exc_out. The entry stores {addr, data, mask, size}.
- Address phase: when the FIFO is non-empty, drive ahb_btrans_out=10, hwrite_out=1, and daddrs_out/hsize_out from the head entry. With the FIFO empty, ahb_btrans_out=00.
- The address phase is accepted on the rising edge with NONSEQ and ahb_ready_in=1. That edge pops the head into the data-phase register. The next cycle drives data_out/wr_mask_out from it.
- The data phase completes on the first edge with ahb_ready_in=1. While ahb_ready_in=0, address- and data-phase outputs are held stable. The head cannot change because pushes enter at the tail.
- Pipelining: the next entry's address phase overlaps the current data phase. One ahb_ready_in=1 edge both completes data N and accepts address N+1, giving back-to-back throughput of one store per cycle.
- After the last data phase completes with no next address, wr_mask_out returns to 0. data_out holds its last value.
- Simultaneous push and pop: count_out unchanged, both take effect. Pointers wrap modulo DEPTH.
- empty_out = (count_out==0) & ~data-phase-valid.
- Latency: a store accepted at edge T appears as NONSEQ in cycle T+1 if the FIFO was empty. Data is driven in the cycle after address acceptance.

Test Plan:
- SB addr=0x1003, rs2=0xAABBCCDD, ready=1 -> NONSEQ haddr=0x1003 hsize=000; next cycle data_out=0xDD000000, wr_mask_out=1000.
- SH addr=0x2002, rs2=0x00001234 -> data_out=0x12340000, wr_mask_out=1100. SH addr=0x2001 -> exc_out=1, count_out unchanged, no transfer.
- DEPTH=4, ready held 0, five SW requests on consecutive cycles -> count_out reaches 4. The 5th sees stall_out=1 and is dropped. haddr stays at entry 0 throughout.
- Release ready -> four back-to-back transfers. Data phases occur on four consecutive cycles. empty_out rises after the 4th data phase completes.
- Wait state: ready=0 for 3 cycles during a data phase -> data_out, wr_mask_out, daddrs_out and ahb_btrans_out stable. The next address is accepted with the same ready=1 edge.
- Assert rst_in asynchronously mid data phase with 2 entries queued -> all outputs reach reset values immediately, and count_out=0. XLEN=64 SD at addr=0x8 -> hsize=011, wr_mask_out=0xFF; funct3=011 with XLEN=32 -> exc_out=1.
